// File: rtl/sram_like_if.sv
// sram_like_if
//   Bus between an initiator (fetch/memory stage or bench) and a responder.
//   Initiator drives a request; the responder accepts it combinationally with
//   addrok and answers later, in order, with a one-cycle dataok strobe.
//
//   req     initiator -> responder  request valid
//   wr      initiator -> responder  1 = write, 0 = read
//   size    initiator -> responder  0 byte, 1 half, 2 word (wstrb is authoritative)
//   addr    initiator -> responder  byte address
//   wstrb   initiator -> responder  byte write enables (writes only)
//   wdata   initiator -> responder  write data
//   addrok  responder -> initiator  request accepted when req & addrok
//   dataok  responder -> initiator  response strobe, one per accepted request
//   rdata   responder -> initiator  read data, valid with dataok
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addrok;
    logic        dataok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addrok, dataok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addrok, dataok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// sram_like_responder
//   Responder end of the sram-like bus. Each accepted request is issued to a
//   synchronous RAM with one cycle of read latency in the accept cycle. The
//   result is captured the following cycle into an in-order response queue,
//   and each queue head is held for DATA_DELAY extra cycles before it is
//   returned with a registered one-cycle dataok.
//
//   Parameters
//     RAM_AW      word-index width of the backing RAM (4*2^RAM_AW bytes)
//     DEPTH       max outstanding requests, power of two, >= 2
//     DATA_DELAY  extra cycles each response waits at the queue head, 0..15
//
//   Ports
//     i_clk         clock, all state on the rising edge
//     i_rst         asynchronous active-high reset
//     bus           sram-like bus, responder side
//     i_addr_stall  test hook, forces addrok low while high
//     o_ram_en      RAM access enable (only in a handshake cycle)
//     o_ram_wen     RAM byte write enables
//     o_ram_addr    RAM word index
//     o_ram_wdata   RAM write data
//     i_ram_rdata   RAM read data, valid the cycle after a read access
module sram_like_responder #(
    parameter int RAM_AW     = 14,
    parameter int DEPTH      = 4,
    parameter int DATA_DELAY = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sram_like_if.slave        bus,
    input  logic              i_addr_stall,
    output logic              o_ram_en,
    output logic [3:0]        o_ram_wen,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [3:0]    LP_DELAY = 4'(DATA_DELAY);

    // Outstanding requests: includes the one captured from the RAM this cycle.
    logic [CW-1:0] r_count;
    // Entries actually stored in the queue.
    logic [CW-1:0] r_qn;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_q_data [DEPTH];

    // Request accepted last cycle whose RAM result is on i_ram_rdata now.
    logic          r_pend_vld;
    logic          r_pend_wr;

    logic [3:0]    r_age;
    logic          r_dataok;
    logic [31:0]   r_rdata;

    logic          w_hs;
    logic          w_q_empty;
    logic          w_head_vld;
    logic [31:0]   w_pend_data;
    logic [31:0]   w_head_data;
    logic          w_retire;
    logic          w_push;
    logic          w_pop;
    logic          w_unused_bits;

    // Ignored address bits and size: the RAM is word addressed and wraps.
    assign w_unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:RAM_AW+2]};

    assign w_hs = !i_rst && bus.req && !i_addr_stall && (r_count < LP_DEPTH);

    assign bus.addrok  = w_hs;
    assign bus.dataok  = r_dataok;
    assign bus.rdata   = r_rdata;

    assign o_ram_en    = w_hs;
    assign o_ram_wen   = (w_hs && bus.wr) ? bus.wstrb : 4'h0;
    assign o_ram_addr  = bus.addr[RAM_AW+1:2];
    assign o_ram_wdata = bus.wdata;

    // Write responses carry zero data.
    assign w_pend_data = r_pend_wr ? 32'h0 : i_ram_rdata;

    // With an empty queue the entry arriving from the RAM is already the head,
    // so it can age (and, with no delay, retire) without a trip through the
    // queue storage. That is what makes back-to-back dataok possible.
    assign w_q_empty   = (r_qn == '0);
    assign w_head_vld  = !w_q_empty || r_pend_vld;
    assign w_head_data = w_q_empty ? w_pend_data : r_q_data[r_head];
    assign w_retire    = w_head_vld && (r_age == LP_DELAY);

    assign w_push = r_pend_vld && !(w_q_empty && w_retire);
    assign w_pop  = w_retire && !w_q_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= '0;
            r_qn       <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_pend_vld <= 1'b0;
            r_pend_wr  <= 1'b0;
            r_age      <= '0;
            r_dataok   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_pend_vld <= w_hs;
            r_pend_wr  <= bus.wr;

            case ({w_hs, w_retire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_qn <= r_qn + CW'(1);
                2'b01:   r_qn <= r_qn - CW'(1);
                default: r_qn <= r_qn;
            endcase

            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end

            // Age restarts for whichever entry becomes head next.
            if (!w_head_vld || w_retire) begin
                r_age <= '0;
            end else begin
                r_age <= r_age + 4'd1;
            end

            r_dataok <= w_retire;
            if (w_retire) begin
                r_rdata <= w_head_data;
            end
        end
    end

    // Queue storage needs no reset; occupancy is tracked by r_qn.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_data[r_tail] <= w_pend_data;
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;

    localparam int AW    = 14;
    localparam int NW    = 1 << AW;
    localparam int DEPTH = 4;
    localparam int D0    = 0;
    localparam int D1    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stall;

    sram_like_if bus0 ();
    sram_like_if bus1 ();

    assign bus0.req = req;   assign bus1.req = req;
    assign bus0.wr = wr;     assign bus1.wr = wr;
    assign bus0.size = size; assign bus1.size = size;
    assign bus0.addr = addr; assign bus1.addr = addr;
    assign bus0.wstrb = wstrb; assign bus1.wstrb = wstrb;
    assign bus0.wdata = wdata; assign bus1.wdata = wdata;

    logic          ram_en0, ram_en1;
    logic [3:0]    ram_wen0, ram_wen1;
    logic [AW-1:0] ram_addr0, ram_addr1;
    logic [31:0]   ram_wdata0, ram_wdata1;
    logic [31:0]   ram_rdata0, ram_rdata1;

    sram_like_responder #(.RAM_AW(AW), .DEPTH(DEPTH), .DATA_DELAY(D0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0), .i_addr_stall(stall),
        .o_ram_en(ram_en0), .o_ram_wen(ram_wen0), .o_ram_addr(ram_addr0),
        .o_ram_wdata(ram_wdata0), .i_ram_rdata(ram_rdata0)
    );

    sram_like_responder #(.RAM_AW(AW), .DEPTH(DEPTH), .DATA_DELAY(D1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1), .i_addr_stall(stall),
        .o_ram_en(ram_en1), .o_ram_wen(ram_wen1), .o_ram_addr(ram_addr1),
        .o_ram_wdata(ram_wdata1), .i_ram_rdata(ram_rdata1)
    );

    // Synchronous RAMs, one-cycle read latency, byte writes.
    bit [31:0] ram0 [NW];
    bit [31:0] ram1 [NW];

    always @(posedge clk) begin
        if (ram_en0) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen0[b]) ram0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
            ram_rdata0 <= ram0[ram_addr0];
        end
    end

    always @(posedge clk) begin
        if (ram_en1) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen1[b]) ram1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
            ram_rdata1 <= ram1[ram_addr1];
        end
    end

    logic          s_addrok [2];
    logic          s_dataok [2];
    logic [31:0]   s_rdata [2];
    logic          s_ram_en [2];
    logic [3:0]    s_ram_wen [2];
    logic [AW-1:0] s_ram_addr [2];
    logic [31:0]   s_ram_wdata [2];

    assign s_addrok[0] = bus0.addrok;  assign s_addrok[1] = bus1.addrok;
    assign s_dataok[0] = bus0.dataok;  assign s_dataok[1] = bus1.dataok;
    assign s_rdata[0] = bus0.rdata;    assign s_rdata[1] = bus1.rdata;
    assign s_ram_en[0] = ram_en0;      assign s_ram_en[1] = ram_en1;
    assign s_ram_wen[0] = ram_wen0;    assign s_ram_wen[1] = ram_wen1;
    assign s_ram_addr[0] = ram_addr0;  assign s_ram_addr[1] = ram_addr1;
    assign s_ram_wdata[0] = ram_wdata0; assign s_ram_wdata[1] = ram_wdata1;

    // Reference model: memory image plus a list of (due cycle, data) responses.
    bit [31:0]   ref_mem [2][NW];
    int          exp_t [2][64];
    logic [31:0] exp_d [2][64];
    int          qh [2];
    int          qt [2];
    int          cnt [2];
    int          last_t [2];
    int          acc [2];
    logic [31:0] exp_rdata [2];
    int          cyc;
    int          total;
    int          bad;

    function automatic int dly(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    task automatic chk(input int i, input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, expv);
        end
    endtask

    task automatic eval(input int i);
        bit          hs;
        bit          ok;
        int          w;
        int          t;
        logic [31:0] d;
        if (rst) begin
            qh[i] = 0; qt[i] = 0; cnt[i] = 0; last_t[i] = -100; exp_rdata[i] = '0;
            chk(i, "addrok_in_reset", s_addrok[i], 0);
            chk(i, "dataok_in_reset", s_dataok[i], 0);
            chk(i, "ram_en_in_reset", s_ram_en[i], 0);
            chk(i, "rdata_in_reset", s_rdata[i], 0);
            return;
        end
        ok = 0;
        if (qh[i] != qt[i] && exp_t[i][qh[i] % 64] == cyc) begin
            ok = 1;
            exp_rdata[i] = exp_d[i][qh[i] % 64];
            qh[i]++;
            cnt[i]--;
        end
        chk(i, "dataok", s_dataok[i], ok);
        chk(i, "rdata", s_rdata[i], exp_rdata[i]);
        hs = req && !stall && (cnt[i] < DEPTH);
        chk(i, "addrok", s_addrok[i], hs);
        chk(i, "ram_en", s_ram_en[i], hs);
        if (hs) begin
            w = int'((addr >> 2) % NW);
            chk(i, "ram_addr", s_ram_addr[i], w);
            chk(i, "ram_wen", s_ram_wen[i], wr ? wstrb : 4'h0);
            chk(i, "ram_wdata", s_ram_wdata[i], wdata);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) ref_mem[i][w][8*b +: 8] = wdata[8*b +: 8];
                d = '0;
            end else begin
                d = ref_mem[i][w];
            end
            // In-order: a response cannot start ageing before its predecessor leaves.
            t = cyc + 2 + dly(i);
            if (last_t[i] + 1 + dly(i) > t) t = last_t[i] + 1 + dly(i);
            exp_t[i][qt[i] % 64] = t;
            exp_d[i][qt[i] % 64] = d;
            qt[i]++;
            last_t[i] = t;
            cnt[i]++;
            acc[i]++;
        end else begin
            chk(i, "ram_wen_idle", s_ram_wen[i], 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        eval(0);
        eval(1);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic put(input bit r, input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req = r; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    endtask

    int a0;
    int a1;

    initial begin
        total = 0; bad = 0; cyc = 0;
        acc[0] = 0; acc[1] = 0;
        rst = 1'b1; stall = 1'b0;
        put(0, 0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Word write then read of the same word.
        put(1, 1, 32'h100, 4'hF, 32'h1234_5678);
        tick();
        put(1, 0, 32'h100, 4'h0, 32'h0);
        tick();
        put(0, 0, 0, 0, 0);
        chk(0, "t1_write_dataok", s_dataok[0], 1);
        chk(0, "t1_write_rdata", s_rdata[0], 32'h0);
        tick();
        chk(0, "t1_read_dataok", s_dataok[0], 1);
        chk(0, "t1_read_rdata", s_rdata[0], 32'h1234_5678);
        repeat (8) tick();

        // Byte lane write.
        put(1, 1, 32'h101, 4'b0010, 32'h0000_AA00);
        tick();
        put(1, 0, 32'h100, 4'h0, 32'h0);
        tick();
        put(0, 0, 0, 0, 0);
        tick();
        chk(0, "t2_rdata", s_rdata[0], 32'h1234_AA78);
        repeat (8) tick();

        // Request held high for 20 cycles; the delayed instance fills up.
        a0 = acc[0]; a1 = acc[1];
        for (int k = 0; k < 20; k++) begin
            put(1, 0, 32'h100 + 32'(4 * (k % 8)), 4'h0, 32'h0);
            tick();
        end
        chk(0, "t3_accepts_d0", acc[0] - a0, 20);
        chk(1, "t3_accepts_d3", acc[1] - a1, 8);
        put(0, 0, 0, 0, 0);
        repeat (40) tick();

        // Address stall.
        a0 = acc[0];
        stall = 1'b1;
        put(1, 0, 32'h104, 4'h0, 32'h0);
        repeat (5) tick();
        chk(0, "t4_no_accept_stalled", acc[0] - a0, 0);
        stall = 1'b0;
        tick();
        chk(0, "t4_accept_after_stall", acc[0] - a0, 1);
        put(0, 0, 0, 0, 0);
        repeat (10) tick();

        // Reset with reads in flight, then refill the delayed instance.
        put(1, 0, 32'h100, 4'h0, 32'h0);
        repeat (3) tick();
        put(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        a1 = acc[1];
        put(1, 0, 32'h108, 4'h0, 32'h0);
        repeat (4) tick();
        chk(1, "t5_full_depth_after_reset", acc[1] - a1, 4);
        put(0, 0, 0, 0, 0);
        repeat (20) tick();

        // Aliasing of high address bits onto word 0.
        put(1, 1, 32'h0001_0000, 4'hF, 32'hCAFE_F00D);
        @(negedge clk);
        chk(0, "t6_alias_ram_addr", s_ram_addr[0], 0);
        @(posedge clk); #1;
        cyc++;
        cnt[0] = cnt[0]; // model bookkeeping for this hand-timed cycle follows
        for (int i = 0; i < 2; i++) begin
            ref_mem[i][0] = 32'hCAFE_F00D;
            exp_t[i][qt[i] % 64] = (last_t[i] + 1 + dly(i) > cyc + 1 + dly(i)) ? last_t[i] + 1 + dly(i) : cyc + 1 + dly(i);
            exp_d[i][qt[i] % 64] = 32'h0;
            last_t[i] = exp_t[i][qt[i] % 64];
            qt[i]++; cnt[i]++; acc[i]++;
        end
        put(1, 0, 32'hFFFF_0000, 4'h0, 32'h0);
        tick();
        put(0, 0, 0, 0, 0);
        repeat (10) tick();

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            req   = ($urandom % 4) != 0;
            wr    = $urandom % 2;
            size  = 2'($urandom % 3);
            addr  = ($urandom % 2) ? $urandom : (32'h100 + 32'(($urandom % 16) * 4) + 32'($urandom % 4));
            wstrb = 4'($urandom);
            wdata = $urandom;
            stall = ($urandom % 8) == 0;
            rst   = ($urandom % 300) == 0;
            tick();
        end
        rst = 1'b0; stall = 1'b0;
        put(0, 0, 0, 0, 0);
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
